// File: rtl/u_code_sequencer.sv
// Micro-code sequencer sitting between the IF/ID register and the micro-code
// ROM. Matching opcodes dispatch into a ROM routine; while it runs, fetch is
// frozen and the ROM address is walked with sequential, jump and counted-loop
// branches. A step watchdog and an address-overflow check raise a sticky error.
module u_code_sequencer #(
    parameter int INSTR_W     = 32,
    parameter int OPC_MSB     = 31,
    parameter int OPC_LSB     = 25,
    parameter int UADDR_W     = 8,
    parameter int CNT_W       = 6,
    parameter int NUM_ENTRIES = 2,
    parameter logic [NUM_ENTRIES*(OPC_MSB-OPC_LSB+1)-1:0] DISP_OPC  = {7'b0011000, 7'b0010000},
    parameter logic [NUM_ENTRIES*UADDR_W-1:0]             DISP_ADDR = {8'h10, 8'h00},
    parameter int MAX_STEPS   = 255,
    localparam int ENTRY_W    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] ifid_instr,
    input  logic               ifid_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic               uw_end,
    input  logic               uw_jmp,
    input  logic               uw_loop,
    input  logic               uw_ld_cnt,
    input  logic [UADDR_W-1:0] uw_tgt,
    input  logic [CNT_W-1:0]   uw_cnt_val,
    output logic               hold_if,
    output logic               uc_active,
    output logic [UADDR_W-1:0] uc_addr,
    output logic [ENTRY_W-1:0] uc_entry,
    output logic               uc_done,
    output logic               uc_err
);

    localparam int OPC_W  = OPC_MSB - OPC_LSB + 1;
    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS + 1) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   loop_cnt;
    logic [STEP_W-1:0]  step_cnt;

    logic [OPC_W-1:0]   opcode;
    logic               disp_hit;
    logic [ENTRY_W-1:0] disp_idx;
    logic [UADDR_W-1:0] disp_addr;

    logic [UADDR_W-1:0] run_addr;
    logic [CNT_W-1:0]   run_cnt;
    logic               run_seq;
    logic               addr_ovf;
    logic               wdog_hit;

    // Only the opcode field is decoded; the rest of the instruction is ignored.
    logic unused_instr_bits;
    assign unused_instr_bits = ^ifid_instr;

    // Dispatch table lookup; the lowest matching entry wins.
    always_comb begin
        opcode    = ifid_instr[OPC_MSB:OPC_LSB];
        disp_hit  = 1'b0;
        disp_idx  = '0;
        disp_addr = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!disp_hit && opcode == DISP_OPC[i*OPC_W +: OPC_W]) begin
                disp_hit  = 1'b1;
                disp_idx  = ENTRY_W'(i);
                disp_addr = DISP_ADDR[i*UADDR_W +: UADDR_W];
            end
        end
    end

    // Next address / loop counter for a running sequence (uw_end and errors handled in the register block).
    always_comb begin
        run_addr = uc_addr + UADDR_W'(1);
        run_cnt  = loop_cnt;
        run_seq  = 1'b1;
        if (uw_ld_cnt) begin
            run_cnt = uw_cnt_val;
        end else if (uw_loop) begin
            if (loop_cnt != '0) begin
                run_cnt  = loop_cnt - CNT_W'(1);
                run_addr = uw_tgt;
                run_seq  = 1'b0;
            end
        end else if (uw_jmp) begin
            run_addr = uw_tgt;
            run_seq  = 1'b0;
        end
        addr_ovf = run_seq && (uc_addr == '1);
        wdog_hit = (step_cnt == STEP_W'(MAX_STEPS));
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_if   <= 1'b0;
            uc_active <= 1'b0;
            uc_addr   <= '0;
            uc_entry  <= '0;
            uc_done   <= 1'b0;
            uc_err    <= 1'b0;
            loop_cnt  <= '0;
            step_cnt  <= '0;
        end else begin
            // uc_done is a single-cycle pulse even if a stall follows the end.
            uc_done <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                hold_if   <= 1'b0;
                uc_active <= 1'b0;
                uc_addr   <= '0;
                uc_entry  <= '0;
                loop_cnt  <= '0;
                step_cnt  <= '0;
            end else if (!stall) begin
                case (state)
                    IDLE: begin
                        if (ifid_valid && disp_hit) begin
                            state     <= RUN;
                            hold_if   <= 1'b1;
                            uc_active <= 1'b1;
                            uc_addr   <= disp_addr;
                            uc_entry  <= disp_idx;
                            loop_cnt  <= '0;
                            step_cnt  <= '0;
                        end
                    end
                    RUN: begin
                        step_cnt <= step_cnt + STEP_W'(1);
                        if (uw_end) begin
                            state     <= IDLE;
                            hold_if   <= 1'b0;
                            uc_active <= 1'b0;
                            uc_addr   <= '0;
                            uc_done   <= 1'b1;
                        end else if (wdog_hit || addr_ovf) begin
                            state     <= IDLE;
                            hold_if   <= 1'b0;
                            uc_active <= 1'b0;
                            uc_addr   <= '0;
                            uc_err    <= 1'b1;
                            step_cnt  <= '0;
                        end else begin
                            uc_addr  <= run_addr;
                            loop_cnt <= run_cnt;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_u_code_sequencer.sv
// Self-checking bench for u_code_sequencer: a behavioural micro-ROM drives the
// micro-word inputs from uc_addr, and a scoreboard of expected (address, entry)
// pairs is consumed on every cycle the sequencer reports itself active.
module tb_u_code_sequencer;

    localparam logic [6:0] OPC_MUL  = 7'b0010000;
    localparam logic [6:0] OPC_MULS = 7'b0011000;
    localparam logic [6:0] OPC_NONE = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifid_instr = '0;
    logic        ifid_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        uw_end, uw_jmp, uw_loop, uw_ld_cnt;
    logic [7:0]  uw_tgt;
    logic [5:0]  uw_cnt_val;
    logic        hold_if, uc_active, uc_done, uc_err;
    logic [7:0]  uc_addr;
    logic [0:0]  uc_entry;

    logic       rom_end [256];
    logic       rom_jmp [256];
    logic       rom_loop[256];
    logic       rom_ld  [256];
    logic [7:0] rom_tgt [256];
    logic [5:0] rom_cnt [256];

    typedef struct {
        logic [7:0] addr;
        logic       entry;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic [12:0] got;

    u_code_sequencer dut (
        .clk(clk), .rst(rst), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .stall(stall), .flush(flush), .uw_end(uw_end), .uw_jmp(uw_jmp),
        .uw_loop(uw_loop), .uw_ld_cnt(uw_ld_cnt), .uw_tgt(uw_tgt),
        .uw_cnt_val(uw_cnt_val), .hold_if(hold_if), .uc_active(uc_active),
        .uc_addr(uc_addr), .uc_entry(uc_entry), .uc_done(uc_done), .uc_err(uc_err)
    );

    always #5 clk = ~clk;

    assign uw_end     = rom_end[uc_addr];
    assign uw_jmp     = rom_jmp[uc_addr];
    assign uw_loop    = rom_loop[uc_addr];
    assign uw_ld_cnt  = rom_ld[uc_addr];
    assign uw_tgt     = rom_tgt[uc_addr];
    assign uw_cnt_val = rom_cnt[uc_addr];
    assign got        = {hold_if, uc_active, uc_addr, uc_entry, uc_done, uc_err};

    // Scoreboard consumer: every active cycle must match the next expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && uc_active === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: active at addr %h entry %0d, expected idle", uc_addr, uc_entry);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (uc_addr !== e.addr || uc_entry !== e.entry || hold_if !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sb_trace: got addr %h entry %0d hold %b, expected addr %h entry %0d hold 1",
                             uc_addr, uc_entry, hold_if, e.addr, e.entry);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) begin
            rom_end[i] = 1'b0; rom_jmp[i] = 1'b0; rom_loop[i] = 1'b0; rom_ld[i] = 1'b0;
            rom_tgt[i] = 8'h00; rom_cnt[i] = 6'd0;
        end
    endtask

    task automatic drive_opc(input logic [6:0] opc);
        ifid_instr = {opc, 25'($urandom)};
        ifid_valid = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic en);
        exp_t e;
        e.addr = a;
        e.entry = en;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rom_clear();
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if (got !== 13'b0) begin n_fail++; $display("FAIL reset_state: got %h expected %h", got, 13'b0); end
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (got !== 13'b0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected %h", got, 13'b0); end
    endtask

    task automatic test_dispatch();
        rom_clear();
        rom_end[2] = 1'b1;
        push_exp(8'h00, 1'b0); push_exp(8'h01, 1'b0); push_exp(8'h02, 1'b0);
        drive_opc(OPC_MUL);
        tick();
        ifid_valid = 1'b0;
        n_checks++;
        if (got !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL dispatch_start: got %h expected %h", got, {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        for (int i = 0; i < 20 && uc_done !== 1'b1; i++) tick();
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL dispatch_done: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        end
        tick();
        n_checks++;
        if (uc_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", uc_done); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL dispatch_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_no_match();
        drive_opc(OPC_NONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (got !== 13'b0) begin n_fail++; $display("FAIL no_match_idle: got %h expected %h", got, 13'b0); end
        end
        ifid_valid = 1'b0;
    endtask

    task automatic test_counted_loop();
        logic [7:0] tr[10];
        tr = '{8'h10, 8'h11, 8'h12, 8'h11, 8'h12, 8'h11, 8'h12, 8'h11, 8'h12, 8'h13};
        rom_clear();
        rom_ld[8'h10] = 1'b1; rom_cnt[8'h10] = 6'd3;
        rom_loop[8'h10] = 1'b1; rom_tgt[8'h10] = 8'h30;   // ld_cnt must suppress this branch
        rom_loop[8'h12] = 1'b1; rom_tgt[8'h12] = 8'h11;
        rom_end[8'h13] = 1'b1;
        rom_jmp[8'h13] = 1'b1; rom_tgt[8'h13] = 8'h40;    // end must win over jump
        for (int i = 0; i < 10; i++) push_exp(tr[i], 1'b1);
        drive_opc(OPC_MULS);
        tick();
        ifid_valid = 1'b0;
        for (int i = 0; i < 30 && uc_done !== 1'b1; i++) tick();
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL loop_done: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL loop_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_stall_run();
        rom_clear();
        rom_end[4] = 1'b1;
        push_exp(8'h00, 1'b0); push_exp(8'h01, 1'b0); push_exp(8'h01, 1'b0); push_exp(8'h01, 1'b0);
        push_exp(8'h02, 1'b0); push_exp(8'h03, 1'b0); push_exp(8'h04, 1'b0);
        drive_opc(OPC_MUL);
        tick();
        ifid_valid = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({hold_if, uc_active, uc_addr} !== {1'b1, 1'b1, 8'h01}) begin
                n_fail++; $display("FAIL stall_freeze: got %h expected %h", {hold_if, uc_active, uc_addr}, {1'b1, 1'b1, 8'h01});
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 20 && uc_done !== 1'b1; i++) tick();
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL stall_done: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_stall_idle();
        rom_clear();
        rom_end[0] = 1'b1;
        stall = 1'b1;
        drive_opc(OPC_MUL);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({hold_if, uc_active} !== 2'b00) begin
                n_fail++; $display("FAIL stall_idle_defer: got %b expected 00", {hold_if, uc_active});
            end
        end
        push_exp(8'h00, 1'b0);
        stall = 1'b0;
        tick();
        ifid_valid = 1'b0;
        n_checks++;
        if ({hold_if, uc_active, uc_addr} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL stall_idle_dispatch: got %h expected %h", {hold_if, uc_active, uc_addr}, {1'b1, 1'b1, 8'h00});
        end
        for (int i = 0; i < 10 && uc_done !== 1'b1; i++) tick();
        n_checks++;
        if (uc_done !== 1'b1) begin n_fail++; $display("FAIL stall_idle_done: got %b expected 1", uc_done); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_idle_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        rom_clear();
        rom_end[1] = 1'b1;
        push_exp(8'h00, 1'b0); push_exp(8'h01, 1'b0); push_exp(8'h00, 1'b0); push_exp(8'h01, 1'b0);
        drive_opc(OPC_MUL);
        tick(); tick(); tick();
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL b2b_first_done: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        end
        tick();
        ifid_valid = 1'b0;
        n_checks++;
        if (got !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL b2b_redispatch: got %h expected %h", got, {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        for (int i = 0; i < 10 && uc_done !== 1'b1; i++) tick();
        n_checks++;
        if (uc_done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", uc_done); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_flush();
        rom_clear();
        rom_end[8'h15] = 1'b1;
        push_exp(8'h10, 1'b1); push_exp(8'h11, 1'b1); push_exp(8'h12, 1'b1);
        drive_opc(OPC_MULS);
        tick();
        ifid_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (got !== 13'b0) begin n_fail++; $display("FAIL flush_idle: got %h expected %h", got, 13'b0); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({uc_active, uc_done} !== 2'b00) begin
                n_fail++; $display("FAIL flush_no_done: got %b expected 00", {uc_active, uc_done});
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_overflow();
        rom_clear();
        rom_jmp[0] = 1'b1; rom_tgt[0] = 8'hFF;
        push_exp(8'h00, 1'b0); push_exp(8'hFF, 1'b0);
        drive_opc(OPC_MUL);
        tick();
        ifid_valid = 1'b0;
        for (int i = 0; i < 20 && uc_active === 1'b1; i++) tick();
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL overflow_err: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL overflow_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_async_reset();
        rom_clear();
        rom_jmp[3] = 1'b1; rom_tgt[3] = 8'h00;
        push_exp(8'h00, 1'b0);
        drive_opc(OPC_MUL);
        tick();
        ifid_valid = 1'b0;
        tick();
        n_checks++;
        if ({uc_active, uc_addr, uc_err} !== {1'b1, 8'h01, 1'b1}) begin
            n_fail++; $display("FAIL pre_reset_run: got %h expected %h", {uc_active, uc_addr, uc_err}, {1'b1, 8'h01, 1'b1});
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (got !== 13'b0) begin n_fail++; $display("FAIL async_reset: got %h expected %h", got, 13'b0); end
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL reset_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_watchdog();
        int act;
        rom_clear();
        rom_jmp[0] = 1'b1; rom_tgt[0] = 8'h00;
        for (int i = 0; i < 256; i++) push_exp(8'h00, 1'b0);
        drive_opc(OPC_MUL);
        tick();
        ifid_valid = 1'b0;
        act = (uc_active === 1'b1) ? 1 : 0;
        for (int i = 0; i < 400 && uc_active === 1'b1; i++) begin
            tick();
            if (uc_active === 1'b1) act++;
        end
        n_checks++;
        if (act != 256) begin n_fail++; $display("FAIL wdog_cycles: got %0d expected 256", act); end
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wdog_err: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wdog_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
        // Error is sticky and does not block further dispatches.
        rom_clear();
        rom_end[2] = 1'b1;
        push_exp(8'h00, 1'b0); push_exp(8'h01, 1'b0); push_exp(8'h02, 1'b0);
        drive_opc(OPC_MUL);
        tick();
        ifid_valid = 1'b0;
        for (int i = 0; i < 20 && uc_done !== 1'b1; i++) tick();
        n_checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL sticky_err_done: got %h expected %h", got, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
        end
        tick(); tick();
        n_checks++;
        if (uc_err !== 1'b1) begin n_fail++; $display("FAIL sticky_err_hold: got %b expected 1", uc_err); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sticky_sb_left: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_no_match();
        test_counted_loop();
        test_stall_run();
        test_stall_idle();
        test_back_to_back();
        test_flush();
        test_overflow();
        test_async_reset();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
